// File: rtl/i2s_codec_model.sv
// i2s_codec_model: I2S slave codec endpoint; deserializes DAC words from SD_in, serializes ADC words onto SD_out.
//   clk/rst_n        system clock, asynchronous active-low reset
//   codec_rst_n      codec reset from the master (synchronized, active-low)
//   LRCLK/SCLK/SD_in I2S bus from the master (oversampled through synchronizers)
//   SD_out           registered serial ADC data, MSB first
//   adc_left/right   ADC words; sampled at each frame start, acknowledged by adc_ack
//   dac_left/right   last received words; dac_valid pulses with each completed left+right pair
//   frame_err        sticky flag: a checked half-frame had a SCLK rise count other than SLOTS
module i2s_codec_model #(
  parameter int WIDTH       = 16,
  parameter int SLOTS       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             codec_rst_n,
  input  logic             LRCLK,
  input  logic             SCLK,
  input  logic             SD_in,
  output logic             SD_out,
  input  logic [WIDTH-1:0] adc_left,
  input  logic [WIDTH-1:0] adc_right,
  output logic             adc_ack,
  output logic [WIDTH-1:0] dac_left,
  output logic [WIDTH-1:0] dac_right,
  output logic             dac_valid,
  output logic             frame_err
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [SYNC_STAGES-1:0] lr_sync, sck_sync, sd_sync, cr_sync;
  logic                   lr_d, sck_d;
  logic                   lr_s, sd_s, crst, lr_rise, lr_fall, sck_rise, sck_fall, start;
  logic [WIDTH-1:0]       tx_shift, rx_shift, hold_l, hold_r, cur_r;
  logic [CW-1:0]          bit_cnt, bit_inc;
  logic [5:0]             rise_cnt;
  logic                   armed, got_left, rx_done, rx_take;
  // The extra lr_d/sck_d stage after the synchronizer gives the edge detectors a clean
  // previous value; this puts the SD_in sample SYNC_STAGES+1 cycles after the SCLK pin rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lr_sync  <= '1;
      sck_sync <= '1;
      sd_sync  <= '0;
      cr_sync  <= '0;
      lr_d     <= 1'b1;
      sck_d    <= 1'b1;
    end else begin
      lr_sync  <= {lr_sync[SYNC_STAGES-2:0], LRCLK};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCLK};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0], SD_in};
      cr_sync  <= {cr_sync[SYNC_STAGES-2:0], codec_rst_n};
      lr_d     <= lr_sync[SYNC_STAGES-1];
      sck_d    <= sck_sync[SYNC_STAGES-1];
    end
  end
  always_comb begin
    lr_s     = lr_sync[SYNC_STAGES-1];
    sd_s     = sd_sync[SYNC_STAGES-1];
    crst     = ~cr_sync[SYNC_STAGES-1];
    lr_rise  = lr_s & ~lr_d;
    lr_fall  = ~lr_s & lr_d;
    sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_d;
    sck_fall = ~sck_sync[SYNC_STAGES-1] & sck_d;
    start    = lr_rise | lr_fall;
    // A rise coincident with a start is bit 1 of the new half-frame. Reception only begins
    // once a real half-frame start has been seen, so a partial half-frame after reset is dropped.
    bit_inc  = (start ? '0 : bit_cnt) + CW'(1);
    rx_take  = sck_rise && (start || (armed && bit_cnt < CW'(WIDTH)));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift  <= '0;
      rx_shift  <= '0;
      hold_l    <= '0;
      hold_r    <= '0;
      cur_r     <= '0;
      bit_cnt   <= '0;
      rise_cnt  <= '0;
      armed     <= 1'b0;
      got_left  <= 1'b0;
      rx_done   <= 1'b0;
      SD_out    <= 1'b0;
      adc_ack   <= 1'b0;
      dac_valid <= 1'b0;
      frame_err <= 1'b0;
      dac_left  <= '0;
      dac_right <= '0;
    end else if (crst) begin
      tx_shift  <= '0;
      rx_shift  <= '0;
      hold_l    <= '0;
      hold_r    <= '0;
      cur_r     <= '0;
      bit_cnt   <= '0;
      rise_cnt  <= '0;
      armed     <= 1'b0;
      got_left  <= 1'b0;
      rx_done   <= 1'b0;
      SD_out    <= 1'b0;
      adc_ack   <= 1'b0;
      dac_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      SD_out  <= tx_shift[WIDTH-1];
      adc_ack <= lr_rise;
      // The load wins over a coincident SCLK fall, so the MSB is the first bit on the wire.
      if (start) begin
        tx_shift <= lr_rise ? hold_l : cur_r;
        armed    <= 1'b1;
        if (armed && rise_cnt != 6'(SLOTS)) frame_err <= 1'b1;
      end else if (sck_fall) begin
        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
      end
      // cur_r keeps the right word of this frame on the previous buffer contents, so words
      // sampled at this frame start are transmitted (both channels) in the next frame.
      if (lr_rise) begin
        hold_l <= adc_left;
        hold_r <= adc_right;
        cur_r  <= hold_r;
      end
      rise_cnt <= start ? {5'd0, sck_rise} : (sck_rise && rise_cnt != 6'd63) ? rise_cnt + 6'd1 : rise_cnt;
      if (rx_take) begin
        rx_shift <= {rx_shift[WIDTH-2:0], sd_s};
        bit_cnt  <= bit_inc;
      end else if (start) begin
        bit_cnt <= '0;
      end
      rx_done <= rx_take && bit_inc == CW'(WIDTH);
      // The pair pulse requires a left word since the last right word, so a right word
      // received alone (first half-frame after reset) updates dac_right without a pulse.
      dac_valid <= rx_done && !lr_s && got_left;
      if (rx_done) begin
        if (lr_s) begin
          dac_left <= rx_shift;
          got_left <= 1'b1;
        end else begin
          dac_right <= rx_shift;
          got_left  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_codec_model.sv
// tb_i2s_codec_model: randomized I2S master driving i2s_codec_model, checked against a frame-level model
module tb_i2s_codec_model;
  localparam int W = 16, SL = 32, HP = 16;
  logic clk = 0, rst_n = 1, codec_rst_n = 1, LRCLK = 1, SCLK = 1, SD_in = 0;
  logic SD_out, adc_ack, dac_valid, frame_err;
  logic [W-1:0] adc_left = 0, adc_right = 0, dac_left, dac_right;
  int vecs = 0, errs = 0, ack_cnt = 0, rs_cnt = 0, cr_cnt = 0, prev_slots = SL;
  logic [W-1:0] nxt_l = 0, nxt_r = 0, cur_r = 0, m_l = 0, m_r = 0;
  bit prev_clean = 0, err_m = 0, got_l = 0;
  logic [2*W-1:0] pair_q[$];

  i2s_codec_model #(.WIDTH(W), .SLOTS(SL), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .codec_rst_n(codec_rst_n), .LRCLK(LRCLK), .SCLK(SCLK),
    .SD_in(SD_in), .SD_out(SD_out), .adc_left(adc_left), .adc_right(adc_right),
    .adc_ack(adc_ack), .dac_left(dac_left), .dac_right(dac_right),
    .dac_valid(dac_valid), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (adc_ack) ack_cnt++;
    if (dac_valid) begin
      chk("valid_pending", 64'(pair_q.size() != 0), 1);
      if (pair_q.size() != 0) chk("valid_pair", {dac_left, dac_right}, pair_q.pop_front());
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rs_cnt > 0) begin
      rs_cnt--;
      if (rs_cnt == 0) rst_n = 1;
    end
    if (cr_cnt > 0) begin
      cr_cnt--;
      if (cr_cnt == 300) begin
        chk("crst_sd_out", SD_out, 0);
        chk("crst_dac_hold", {dac_left, dac_right}, {m_l, m_r});
      end
      if (cr_cnt == 0) codec_rst_n = 1;
    end
  endtask

  task automatic send_half(input bit left, input int slots, input logic [W-1:0] word, input int crl, input int rsl);
    logic [W-1:0] cap = 0, tail = 0, exp_tx;
    bit clean = (crl == 0 && rsl == 0);
    int ack0 = ack_cnt;
    if (prev_clean && prev_slots != SL) err_m = 1;
    exp_tx = left ? nxt_l : cur_r;
    if (left) begin
      cur_r = nxt_r;
      nxt_l = adc_left;
      nxt_r = adc_right;
    end
    if (clean && slots >= W) begin
      if (left) begin
        m_l = word;
        got_l = 1;
      end else begin
        m_r = word;
        if (got_l) pair_q.push_back({m_l, word});
        got_l = 0;
      end
    end
    if (!clean) begin
      nxt_l = 0; nxt_r = 0; cur_r = 0; err_m = 0; got_l = 0;
    end
    if (rsl > 0) begin
      m_l = 0; m_r = 0;
    end
    LRCLK = left;
    for (int s = 0; s < slots; s++) begin
      SCLK = 0;
      SD_in = s < W ? word[W-1-s] : 1'($urandom);
      if (s == 3 && crl > 0) begin
        codec_rst_n = 0;
        cr_cnt = crl;
      end
      if (s == 3 && rsl > 0) begin
        rst_n = 0;
        #1;
        chk("rst_outputs", {SD_out, adc_ack, dac_valid, frame_err, dac_left, dac_right}, 0);
        rs_cnt = rsl;
      end
      repeat (HP) tick();
      if (s < W) cap = {cap[W-2:0], SD_out};
      else tail = {tail[W-2:0], SD_out};
      SCLK = 1;
      repeat (HP) tick();
    end
    if (clean) begin
      chk(left ? "tx_left" : "tx_right", cap, exp_tx);
      chk("tx_tail_zero", tail, 0);
    end
    chk("frame_err", frame_err, err_m);
    chk("dac_left", dac_left, m_l);
    chk("dac_right", dac_right, m_r);
    chk("adc_ack_count", 64'(ack_cnt - ack0), left ? 1 : 0);
    prev_clean = clean;
    prev_slots = slots;
  endtask

  task automatic frame(input logic [W-1:0] l, input logic [W-1:0] r, input int lslots, input int crl, input int rsl);
    send_half(1, lslots, l, crl, rsl);
    adc_left = 16'($urandom);
    adc_right = 16'($urandom);
    send_half(0, SL, r, 0, 0);
  endtask

  initial begin
    rst_n = 0;
    repeat (4) tick();
    chk("reset_state", {SD_out, adc_ack, dac_valid, frame_err, dac_left, dac_right}, 0);
    rst_n = 1;
    repeat (10) tick();
    send_half(0, SL, 16'($urandom), 0, 0);
    adc_left = 16'h8001;
    adc_right = 16'h7FFE;
    frame(16'hA5C3, 16'h1234, SL, 0, 0);
    repeat (4) frame(16'($urandom), 16'($urandom), SL, 0, 0);
    frame(16'($urandom), 16'($urandom), SL - 1, 0, 0);
    repeat (2) frame(16'($urandom), 16'($urandom), SL, 0, 0);
    frame(16'($urandom), 16'($urandom), SL, 8, 0);
    repeat (3) frame(16'($urandom), 16'($urandom), SL, 0, 0);
    frame(16'($urandom), 16'($urandom), SL, 600, 0);
    repeat (3) frame(16'($urandom), 16'($urandom), SL, 0, 0);
    frame(16'($urandom), 16'($urandom), SL, 0, 40);
    repeat (3) frame(16'($urandom), 16'($urandom), SL, 0, 0);
    repeat (50) tick();
    chk("pairs_drained", 64'(pair_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
